// File: rtl/pll_reset_ctrl_if.sv
// PLL control/status bundle between pll_reset_ctrl (master) and the PLL/system side (slave).
// PLL_RST_CTRL_SW_RESTART_EN adds the software restart level.
interface pll_reset_ctrl_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_lost_cnt;
`ifdef PLL_RST_CTRL_SW_RESTART_EN
  logic       restart;

  modport master (
    input  pll_locked, restart,
    output pll_rst, sys_rst, ready, fail, retry_count, lock_lost_cnt
  );
  modport slave (
    output pll_locked, restart,
    input  pll_rst, sys_rst, ready, fail, retry_count, lock_lost_cnt
  );
`else
  modport master (
    input  pll_locked,
    output pll_rst, sys_rst, ready, fail, retry_count, lock_lost_cnt
  );
  modport slave (
    output pll_locked,
    input  pll_rst, sys_rst, ready, fail, retry_count, lock_lost_cnt
  );
`endif
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock monitor: pulses pll_rst, waits for stable lock, releases sys_rst.
// Optional PLL_RST_CTRL_SW_RESTART_EN adds a rising-edge software restart from any state.
module pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input logic              refclk,
  input logic              rst,
  pll_reset_ctrl_if.master bus
);

  localparam int unsigned MaxAB     = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCycles = (MaxAB > STABLE_CYCLES) ? MaxAB : STABLE_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [3:0]      MaxRetry    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {StReset, StWaitLock, StStable, StRun, StFail} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  logic [3:0]             retry_q, retry_d;
  logic [7:0]             lost_q, lost_d;
  logic                   pll_rst_q, sys_rst_q, ready_q, fail_q;
  logic                   restart_rise;
  logic                   enter;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end
  assign lk_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_RST_CTRL_SW_RESTART_EN
  logic restart_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      restart_q <= 1'b0;
    end else begin
      restart_q <= bus.restart;
    end
  end
  assign restart_rise = bus.restart & ~restart_q;
`else
  assign restart_rise = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    unique case (state_q)
      StReset: begin
        if (cnt_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        // Lock wins over a timeout landing on the same edge.
        if (lk_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == MaxRetry) ? StFail : StReset;
        end
      end
      StStable: begin
        if (!lk_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          retry_d = '0;
        end
      end
      StRun: begin
        if (!lk_s) begin
          state_d = StReset;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      StFail: ;
      default: state_d = StReset;
    endcase

    if (restart_rise) begin
      state_d = StReset;
      retry_d = '0;
      lost_d  = lost_q;
    end

    // Shared counter restarts on every entry, including a restart into StReset.
    enter = (state_d != state_q) || restart_rise;
    if (enter || state_q == StRun || state_q == StFail) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= (state_d == StReset) || (state_d == StFail);
      sys_rst_q <= (state_d != StRun);
      ready_q   <= (state_d == StRun);
      fail_q    <= (state_d == StFail);
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst       = sys_rst_q;
  assign bus.ready         = ready_q;
  assign bus.fail          = fail_q;
  assign bus.retry_count   = retry_q;
  assign bus.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl: timed expectations are queued with the stimulus
// and compared as each refclk edge elapses.
module tb_pll_reset_ctrl;

  localparam logic [15:0] MCtl  = 16'hF000;
  localparam logic [15:0] MRty  = 16'h0F00;
  localparam logic [15:0] MLost = 16'h00FF;

  typedef struct {
    int          cyc;
    string       tag;
    logic [15:0] mask;
    logic [15:0] val;
  } exp_t;

  logic refclk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;

  pll_reset_ctrl_if bus ();

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .STABLE_CYCLES      (8),
    .MAX_RETRIES        (2),
    .SYNC_STAGES        (2)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // {pll_rst, sys_rst, ready, fail, retry_count, lock_lost_cnt}
  function automatic logic [15:0] obs();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fail, bus.retry_count, bus.lock_lost_cnt};
  endfunction

  function automatic logic [15:0] ctl(bit p, bit s, bit r, bit f);
    return {p, s, r, f, 12'h000};
  endfunction

  function automatic logic [15:0] rty(int n);
    logic [3:0] v;
    v = n[3:0];
    return {4'h0, v, 8'h00};
  endfunction

  function automatic logic [15:0] lost(int n);
    logic [7:0] v;
    v = n[7:0];
    return {8'h00, v};
  endfunction

  task automatic push(int c, string tag, logic [15:0] m, logic [15:0] v);
    exp_t x;
    int   i;
    x.cyc  = c;
    x.tag  = tag;
    x.mask = m;
    x.val  = v & m;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, x);
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge refclk);
    @(posedge refclk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pll_locked = 1'b0;
`ifdef PLL_RST_CTRL_SW_RESTART_EN
    bus.restart = 1'b0;
`endif
    #2 rst = 1'b1;
    #1;
    checks++;
    if ((obs() & MCtl) !== ctl(1, 1, 0, 0)) begin
      errors++;
      $display("FAIL rst_ctl got=%h exp=%h", obs() & MCtl, ctl(1, 1, 0, 0));
    end
    checks++;
    if ((obs() & (MRty | MLost)) !== 16'h0000) begin
      errors++;
      $display("FAIL rst_cnt got=%h exp=0000", obs() & (MRty | MLost));
    end
  endtask

  task automatic test_bringup();
    apply_reset();
    for (int c = 1; c <= 3; c++) push(c, "bu_pll_hi", MCtl, ctl(1, 1, 0, 0));
    push(4, "bu_pll_lo", MCtl, ctl(0, 1, 0, 0));
    push(19, "bu_pre_run", MCtl, ctl(0, 1, 0, 0));
    push(20, "bu_run", MCtl | MRty, ctl(0, 0, 1, 0) | rty(0));
    for (int t = 1; t <= 22; t++) begin
      step();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", e.tag, cyc, obs() & e.mask, e.val);
        end
      end
      if (t == 9) bus.pll_locked = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bu_pending got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_lock_loss();
    int b;
    for (int k = 1; k <= 300; k++) begin
      b = cyc;
      bus.pll_locked = 1'b0;
      push(b + 3, "ll_drop", MCtl | MLost, ctl(1, 1, 0, 0) | lost((k > 255) ? 255 : k));
      push(b + 16, "ll_rerun", MCtl, ctl(0, 0, 1, 0));
      if (k == 1) begin
        push(b + 2, "ll_hold", MCtl, ctl(0, 0, 1, 0));
        push(b + 6, "ll_pll_hi", MCtl, ctl(1, 1, 0, 0));
        push(b + 7, "ll_pll_lo", MCtl, ctl(0, 1, 0, 0));
        push(b + 15, "ll_pre_run", MCtl, ctl(0, 1, 0, 0));
      end
      for (int t = 1; t <= 18; t++) begin
        step();
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          checks++;
          if ((obs() & e.mask) !== e.val || e.cyc != cyc) begin
            errors++;
            $display("FAIL %s k=%0d cyc=%0d got=%h exp=%h", e.tag, k, cyc, obs() & e.mask,
                     e.val);
          end
        end
        if (t == 3) bus.pll_locked = 1'b1;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ll_pending got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_reset_mid_stable();
    int b;
    b = cyc;
    bus.pll_locked = 1'b0;
    push(b + 11, "ar_stable", MCtl, ctl(0, 1, 0, 0));
    for (int t = 1; t <= 11; t++) begin
      step();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", e.tag, cyc, obs() & e.mask, e.val);
        end
      end
      if (t == 3) bus.pll_locked = 1'b1;
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ((obs() & MCtl) !== ctl(1, 1, 0, 0)) begin
      errors++;
      $display("FAIL ar_ctl got=%h exp=%h", obs() & MCtl, ctl(1, 1, 0, 0));
    end
    checks++;
    if ((obs() & (MRty | MLost)) !== 16'h0000) begin
      errors++;
      $display("FAIL ar_cnt got=%h exp=0000", obs() & (MRty | MLost));
    end
    @(posedge refclk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 3; c++) push(c, "ar_pll_hi", MCtl, ctl(1, 1, 0, 0));
    push(4, "ar_pll_lo", MCtl, ctl(0, 1, 0, 0));
    push(12, "ar_pre_run", MCtl, ctl(0, 1, 0, 0));
    push(13, "ar_run", MCtl | MLost, ctl(0, 0, 1, 0) | lost(0));
    for (int t = 1; t <= 15; t++) begin
      step();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", e.tag, cyc, obs() & e.mask, e.val);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ar_pending got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_chatter();
    bus.pll_locked = 1'b0;
    apply_reset();
    push(25, "ch_pre_run", MCtl | MRty, ctl(0, 1, 0, 0) | rty(0));
    push(26, "ch_run", MCtl | MRty, ctl(0, 0, 1, 0) | rty(0));
    for (int t = 1; t <= 28; t++) begin
      step();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", e.tag, cyc, obs() & e.mask, e.val);
        end
      end
      if (t == 9)  bus.pll_locked = 1'b1;
      if (t == 14) bus.pll_locked = 1'b0;
      if (t == 15) bus.pll_locked = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ch_pending got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_lock_never();
    bus.pll_locked = 1'b0;
    apply_reset();
    push(23, "ln_wait1", MCtl | MRty, ctl(0, 1, 0, 0) | rty(0));
    push(24, "ln_retry1", MCtl | MRty, ctl(1, 1, 0, 0) | rty(1));
    push(27, "ln_pll_hi", MCtl, ctl(1, 1, 0, 0));
    push(28, "ln_pll_lo", MCtl | MRty, ctl(0, 1, 0, 0) | rty(1));
    push(47, "ln_wait2", MCtl | MRty, ctl(0, 1, 0, 0) | rty(1));
    for (int c = 48; c <= 160; c++) push(c, "ln_fail", MCtl | MRty, ctl(1, 1, 0, 1) | rty(2));
    for (int t = 1; t <= 162; t++) begin
      step();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", e.tag, cyc, obs() & e.mask, e.val);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ln_pending got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

`ifdef PLL_RST_CTRL_SW_RESTART_EN
  task automatic test_sw_restart();
    int c;
    c = cyc;
    bus.restart    = 1'b1;
    bus.pll_locked = 1'b1;
    push(c + 1, "sr_reset", MCtl | MRty, ctl(1, 1, 0, 0) | rty(0));
    push(c + 13, "sr_pre_run", MCtl, ctl(0, 1, 0, 0));
    push(c + 14, "sr_run", MCtl | MRty, ctl(0, 0, 1, 0) | rty(0));
    for (int t = 1; t <= 16; t++) begin
      step();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", e.tag, cyc, obs() & e.mask, e.val);
        end
      end
      if (t == 1) bus.restart = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sr_pending got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_bringup();
    test_lock_loss();
    test_async_reset_mid_stable();
    test_chatter();
    test_lock_never();
`ifdef PLL_RST_CTRL_SW_RESTART_EN
    test_sw_restart();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
